// File: rtl/uart_tx_frame.sv
// 8-bit UART frame transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2); the port list is unchanged.
//
// state  | meaning
// IDLE   | line high, waiting for send
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | odd/even parity bit
// STOP   | first stop bit (high)
// STOP2  | second stop bit (UART_TX_TWO_STOP_EN only)
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    output logic       data_tx,
    output logic       active_flag,
    output logic       done_flag
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        STOP2  = 3'd5,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  ptype_q, ptype_d;
    logic        tx_d, active_d, done_d;
    logic        bit_end;
    logic        has_parity;

    assign bit_end    = (cnt_q == LAST_CNT);
    assign has_parity = (ptype_q == 2'b01) || (ptype_q == 2'b10);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            ptype_q     <= '0;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            ptype_q     <= ptype_d;
            data_tx     <= tx_d;
            active_flag <= active_d;
            done_flag   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptype_d = ptype_q;
        idx_d   = idx_q;
        cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (send) begin
                    state_d = START;
                    data_d  = data_in;
                    ptype_d = parity_type;
                end
            end
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = has_parity ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:   if (bit_end) state_d = STOP2;
            STOP2:  if (bit_end) state_d = IDLE;
`else
            STOP:   if (bit_end) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so the registered line
    // changes in the same cycle the state does.
    always_comb begin
        tx_d     = 1'b1;
        active_d = (state_d != IDLE);
        done_d   = (state_q != IDLE) && (state_d == IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = (ptype_d == 2'b01) ? ~^data_d : ^data_d;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-level model checked every cycle plus literal line patterns.
// Adapts to the UART_TX_TWO_STOP_EN build through the stop-bit count.
module tb_uart_tx_frame;

    localparam int C = 16;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic       data_tx, active_flag, done_flag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
        .clock(clock), .reset(reset), .send(send), .data_in(data_in),
        .parity_type(parity_type), .data_tx(data_tx),
        .active_flag(active_flag), .done_flag(done_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a list of line bits, each held C cycles, then one done cycle.
    bit   m_busy = 1'b0;
    int   m_pos = 0;
    int   m_nbits = 0;
    logic m_bits [0:11];
    logic exp_tx = 1'b1, exp_act = 1'b0, exp_done = 1'b0;
    bit   chk_en = 1'b0;

    task automatic model_step();
        int ones;
        int n;
        if (reset) begin
            m_busy = 1'b0; exp_tx = 1'b1; exp_act = 1'b0; exp_done = 1'b0; chk_en = 1'b1;
        end else if (m_busy) begin
            m_pos++;
            if (m_pos == m_nbits * C) begin
                m_busy = 1'b0; exp_tx = 1'b1; exp_act = 1'b0; exp_done = 1'b1;
            end else begin
                exp_tx = m_bits[m_pos / C]; exp_act = 1'b1; exp_done = 1'b0;
            end
        end else begin
            exp_done = 1'b0;
            if (send) begin
                ones = 0;
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_bits[1 + i] = data_in[i];
                    ones += int'(data_in[i]);
                end
                n = 9;
                if (parity_type == 2'b01) begin
                    m_bits[9] = (ones % 2 == 0); n = 10;
                end else if (parity_type == 2'b10) begin
                    m_bits[9] = (ones % 2 == 1); n = 10;
                end
                for (int s = 0; s < NSTOP; s++) m_bits[n + s] = 1'b1;
                m_nbits = n + NSTOP;
                m_pos = 0; m_busy = 1'b1; exp_tx = 1'b0; exp_act = 1'b1;
            end else begin
                exp_tx = 1'b1; exp_act = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("model data_tx", 32'(data_tx), 32'(exp_tx));
            check("model active_flag", 32'(active_flag), 32'(exp_act));
            check("model done_flag", 32'(done_flag), 32'(exp_done));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Sends one frame, samples each bit at mid-period and measures start-to-done cycles.
    // nb counts bits up to and including the first stop bit.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] pt,
                             input logic [11:0] exp_bits, input int nb, input int inject_at);
        logic [11:0] got;
        int done_t;
        got = '0;
        done_t = -1;
        @(negedge clock);
        send = 1'b1; data_in = d; parity_type = pt;
        @(negedge clock);
        send = 1'b0;
        data_in = 8'($urandom_range(255));
        parity_type = 2'($urandom_range(3));
        for (int t = 0; t < 400; t++) begin
            if (t == inject_at) begin
                send = 1'b1; data_in = 8'hFF;
            end else begin
                send = 1'b0;
            end
            if (t % C == C / 2 && t / C < nb) got[t / C] = data_tx;
            if (done_flag) begin
                done_t = t;
                break;
            end
            @(negedge clock);
        end
        send = 1'b0;
        check({name, " bits"}, 32'(got), 32'(exp_bits));
        check({name, " length"}, 32'(done_t), 32'((nb - 1 + NSTOP) * C));
    endtask

    initial begin
        int seen;
        int hi_run;
        bit found;

        repeat (3) @(negedge clock);
        check("reset data_tx", 32'(data_tx), 32'd1);
        check("reset active_flag", 32'(active_flag), 32'd0);
        check("reset done_flag", 32'(done_flag), 32'd0);
        reset = 1'b0;
        wait_cyc(3);

        run_frame("even 55", 8'h55, 2'b10, 12'h4AA, 11, -1);
        wait_cyc(5);
        run_frame("odd 01", 8'h01, 2'b01, 12'h402, 11, -1);
        run_frame("even 01", 8'h01, 2'b10, 12'h602, 11, -1);
        run_frame("none11 A3", 8'hA3, 2'b11, 12'h346, 10, -1);
        run_frame("none00 80", 8'h80, 2'b00, 12'h300, 10, -1);
        run_frame("ignored send", 8'h3C, 2'b00, 12'h278, 10, 3 * C + 4);

        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (active_flag) seen++;
        end
        check("no second frame", 32'(seen), 32'd0);

        // Abort a frame mid-DATA with a one-cycle reset.
        @(negedge clock);
        send = 1'b1; data_in = 8'h55; parity_type = 2'b10;
        @(negedge clock);
        send = 1'b0;
        wait_cyc(40);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort data_tx", 32'(data_tx), 32'd1);
        check("abort active_flag", 32'(active_flag), 32'd0);
        seen = 0;
        repeat (200) begin
            @(negedge clock);
            if (done_flag) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        run_frame("after reset A3", 8'hA3, 2'b11, 12'h346, 10, -1);

        // send held through the done cycle: stop bits, done, then start bit at once.
        @(negedge clock);
        send = 1'b1; data_in = 8'h01; parity_type = 2'b01;
        hi_run = 0;
        found = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clock);
            if (data_tx) hi_run++;
            else hi_run = 0;
            if (done_flag) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b done seen", 32'(found), 32'd1);
        check("b2b stop high run", 32'(hi_run), 32'(NSTOP * C + 1));
        @(negedge clock);
        send = 1'b0;
        check("b2b start data_tx", 32'(data_tx), 32'd0);
        check("b2b start active", 32'(active_flag), 32'd1);
        found = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (done_flag) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b second done", 32'(found), 32'd1);
        wait_cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port send  input  1  request to transmit one frame; sampled only in IDLE.
REQ-005 SHALL have port data_in  input  8  payload byte, latched on acceptance.
REQ-006 SHALL have port parity_type  input  2  parity mode: 00 none, 01 odd, 10 even, 11 none; latched on acceptance.
REQ-007 SHALL have port data_tx  output  1  serial line, idle high.
REQ-008 SHALL have port active_flag  output  1  high while a frame is on the line.
REQ-009 SHALL have port done_flag  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP (plus STOP2, see Configuration).
REQ-011 SHALL, in IDLE with send=1, latch data_in and parity_type and enter START on the next edge.
REQ-012 SHALL drive data_tx low in START, starting the cycle after acceptance (latency 1 cycle).
REQ-013 SHALL hold every bit (start, data, parity, stop) on data_tx for exactly CLKS_PER_BIT cycles, using a bit-period counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-014 SHALL transmit the 8 data bits LSB first in DATA, using a 3-bit index that advances on each counter wrap.
REQ-015 SHALL go DATA->PARITY after bit 7 for parity_type 01/10 and DATA->STOP for 00/11.
REQ-016 SHALL drive parity bit = XNOR-reduce(data) for odd and XOR-reduce(data) for even, so that total ones in data+parity are odd or even respectively.
REQ-017 SHALL drive data_tx high in STOP and in IDLE.
REQ-018 SHALL return to IDLE at the end of the last stop bit and assert done_flag for exactly the first IDLE cycle.
REQ-019 SHALL accept a send asserted during the done_flag cycle, with no idle gap beyond that cycle.
REQ-020 SHALL assert active_flag in every non-IDLE state and deassert it in IDLE.
REQ-021 SHALL ignore send while active_flag=1; data_in and parity_type changes mid-frame SHALL NOT affect the frame.
REQ-022 SHALL produce frame length (11 bits with parity, 10 without) * CLKS_PER_BIT cycles from first start-bit cycle to done_flag cycle.
REQ-023 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, enter IDLE and clear counters, index and latched registers.
REQ-025 SHALL drive data_tx=1, active_flag=0, done_flag=0 from the edge at which reset is sampled.
REQ-026 SHALL abort an in-progress frame on reset and SHALL NOT pulse done_flag for it.
REQ-027 SHALL give reset priority over send in the same cycle.

Configuration
REQ-028 SHALL support macro UART_TX_TWO_STOP_EN.
REQ-029 SHALL, with UART_TX_TWO_STOP_EN defined, insert state STOP2 after STOP (data_tx high, CLKS_PER_BIT cycles), making frames 12/11 bits long.
REQ-030 SHALL, without UART_TX_TWO_STOP_EN, contain no STOP2 state and send one stop bit; the port list SHALL be identical in both builds.

Verification (CLKS_PER_BIT=16, single stop bit unless noted)
REQ-031 SHALL verify send=1, data_in=0x55, parity_type=10 -> line 0,1,0,1,0,1,0,1,0,0(parity),1, each 16 cycles; done_flag 176 cycles after first start-bit cycle.
REQ-032 SHALL verify data_in=0x01 with parity_type=01 -> parity bit 0, and with parity_type=10 -> parity bit 1.
REQ-033 SHALL verify data_in=0xA3, parity_type=11 -> 10-bit frame 0,1,1,0,0,0,1,0,1,1; done_flag after 160 cycles.
REQ-034 SHALL verify send pulsed at bit 3 of an active frame with data_in=0xFF -> ignored; original byte finishes unchanged; no second frame.
REQ-035 SHALL verify reset=1 for one cycle mid-DATA -> next cycle data_tx=1, active_flag=0; no done_flag; a following send starts a clean frame.
REQ-036 SHALL verify send held high in the done_flag cycle with UART_TX_TWO_STOP_EN defined -> two stop bits (32 cycles high), then start bit in the cycle after done_flag.
